// File: rtl/dshot_tx.sv
// dshot_tx: DShot150 frame transmitter.
// Builds {throttle, telem_req, crc4}, sends it MSB-first as pulse-width coded
// bits and then holds the line low for the inter-frame gap.
// Optional build macro: DSHOT_TX_REPEAT_EN (continuous streaming; the last
// word is retransmitted until a new request is accepted on the final gap cycle).
//
// Handshake: a request is taken on any clk edge where tx_valid && tx_ready.
// tx_valid may be raised at any time and does not have to wait for tx_ready.
// throttle/telem_req are only sampled on that accept edge. tx_ready is never
// high while a frame is in flight, except on the final gap cycle in streaming
// builds.
module dshot_tx #(
    parameter int CLKS_PER_BIT = 107,
    parameter int CLKS_T1H     = 80,
    parameter int CLKS_T0H     = 40,
    parameter int GAP_CLKS     = 214
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] throttle,
    input  logic        telem_req,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        dshot_out,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] tx_word
);

    localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);
    localparam logic [CW-1:0] T1H_C    = CW'(CLKS_T1H);
    localparam logic [CW-1:0] T0H_C    = CW'(CLKS_T0H);

    // Timing parameters must give a distinguishable 0/1 pulse inside one bit.
    if (!(CLKS_T0H > 0 && CLKS_T0H < CLKS_T1H && CLKS_T1H < CLKS_PER_BIT)) begin : g_bad_timing
        $error("dshot_tx: need 0 < CLKS_T0H < CLKS_T1H < CLKS_PER_BIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // FSM state is kept as a plain named signal so checkers can bind to it.
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [15:0]   word_n;
    logic          accept;
    logic [11:0]   data12;
    logic [15:0]   frame_word;

    logic          dshot_n, ready_n, busy_n, done_n;

    // Frame word: 12 data bits followed by the nibble-XOR checksum.
    always_comb begin
        data12     = {throttle, telem_req};
        frame_word = {data12, data12[11:8] ^ data12[7:4] ^ data12[3:0]};
    end

    // Next-state, counters and the next value of every registered output.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        word_n    = tx_word;
        accept    = tx_valid && tx_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    word_n    = frame_word;
                    bit_idx_n = 4'd15;
                    cnt_n     = '0;
                    state_n   = BIT;
                end
            end
            BIT: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 4'd0) begin
                        state_n = GAP;
                    end else begin
                        bit_idx_n = bit_idx - 4'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
`ifdef DSHOT_TX_REPEAT_EN
                    // Streaming: either a fresh word or a resend of the last one.
                    bit_idx_n = 4'd15;
                    state_n   = BIT;
                    if (accept) begin
                        word_n = frame_word;
                    end
`else
                    state_n = IDLE;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        dshot_n = (state_n == BIT) && (cnt_n < (word_n[bit_idx_n] ? T1H_C : T0H_C));
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == GAP) && (cnt_n == GAP_LAST);
`ifdef DSHOT_TX_REPEAT_EN
        ready_n = (state_n == IDLE) || done_n;
`else
        ready_n = (state_n == IDLE);
`endif
    end

    // State, counters and all outputs register together; reset drops a partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 4'd15;
            tx_word    <= 16'h0000;
            dshot_out  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_ready   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            tx_word    <= word_n;
            dshot_out  <= dshot_n;
            busy       <= busy_n;
            frame_done <= done_n;
            tx_ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_dshot_tx.sv
// tb_dshot_tx: directed bench for dshot_tx. A line monitor decodes pulse
// widths back into 16-bit words and compares them against an expected queue.
// Build with +define+DSHOT_TX_REPEAT_EN to exercise the streaming variant.
module tb_dshot_tx;

    localparam int PER  = 107;
    localparam int T1H  = 80;
    localparam int T0H  = 40;
    localparam int GAP  = 214;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] throttle = '0;
    logic        telem_req = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        dshot_out;
    logic        busy;
    logic        frame_done;
    logic [15:0] tx_word;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [15:0] exp_q[$];

    dshot_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .throttle   (throttle),
        .telem_req  (telem_req),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dshot_out  (dshot_out),
        .busy       (busy),
        .frame_done (frame_done),
        .tx_word    (tx_word)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line monitor: measure high/low runs, decode bits, check framing.
    int          hi = 0;
    int          lo = 0;
    int          hi_prev = 0;
    int          nbits = 0;
    bit          seen_frame = 1'b0;
    logic [15:0] mon_word = '0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            hi = 0; lo = 0; nbits = 0; seen_frame = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (dshot_out) begin
                if (hi == 0) begin
                    if (nbits > 0) begin
                        check("bit_period", hi_prev + lo, PER);
                    end else if (seen_frame) begin
`ifdef DSHOT_TX_REPEAT_EN
                        check("gap_exact", lo, PER - hi_prev + GAP);
`else
                        check("gap_min", 32'(lo >= PER - hi_prev + GAP), 1);
`endif
                    end
                    lo = 0;
                end
                hi++;
            end else begin
                if (hi > 0) begin
                    check("pulse_width", 32'(hi == T1H || hi == T0H), 1);
                    mon_word = {mon_word[14:0], (hi == T1H)};
                    hi_prev = hi;
                    hi = 0;
                    lo = 0;
                    nbits++;
                    if (nbits == 16) begin
                        e = 'x;
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        check("frame_word", mon_word, e);
                        nbits = 0;
                        seen_frame = 1'b1;
                    end
                end
                lo++;
            end
        end
    end

    // Drive one request; returns at the negedge of the first BIT cycle.
    task automatic send(input logic [10:0] thr, input logic tlm, input logic [15:0] expw);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        check("ready_timeout", 32'(k < 4000), 1);
        throttle  = thr;
        telem_req = tlm;
        tx_valid  = 1'b1;
        exp_q.push_back(expw);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_word_latched", tx_word, expw);
        check("first_cycle_high", dshot_out, 1);
        check("busy_after_accept", busy, 1);
        check("ready_low_in_frame", tx_ready, 0);
    endtask

    // Count negedges until frame_done is seen (bounded).
    task automatic wait_done(output int cyc);
        for (cyc = 1; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (frame_done) break;
        end
        check("done_timeout", 32'(cyc < 4000), 1);
    endtask

    initial begin
        int cyc;
        int highs;
        int d0;

        // 1: reset and quiet idle line
        repeat (5) @(negedge clk);
        check("rst_dshot", dshot_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_word", tx_word, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1);
        check("idle_busy", busy, 0);
        highs = 0;
        repeat (500) begin
            @(negedge clk);
            if (dshot_out) highs++;
        end
        check("idle_no_toggle", highs, 0);

`ifndef DSHOT_TX_REPEAT_EN
        // 2: full throttle, frame timing
        send(11'h7FF, 1'b0, 16'hFFEE);
        wait_done(cyc);
        check("accept_to_done", cyc + 1, 1926);
        check("busy_at_done", busy, 1);
        check("ready_at_done", tx_ready, 0);
        @(negedge clk);
        check("ready_after_gap", tx_ready, 1);
        check("busy_after_gap", busy, 0);

        // 3: mixed bit pattern
        send(11'h6F5, 1'b0, 16'hDEA9);
        wait_done(cyc);
        check("done_dea9", cyc + 1, 1926);

        // 4: inputs change mid-frame, then back-to-back from IDLE
        send(11'h000, 1'b1, 16'h0011);
        repeat (7 * PER + 5) @(negedge clk);
        throttle  = 11'h7FF;
        telem_req = 1'b0;
        tx_valid  = 1'b1;
        @(negedge clk);
        check("ready_low_bit8", tx_ready, 0);
        check("word_held", tx_word, 16'h0011);
        wait_done(cyc);
        check("ready_low_last_gap", tx_ready, 0);
        exp_q.push_back(16'hFFEE);
        @(negedge clk);
        check("b2b_idle_ready", tx_ready, 1);
        check("b2b_idle_low", dshot_out, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_high", dshot_out, 1);
        check("b2b_word", tx_word, 16'hFFEE);
        wait_done(cyc);
        check("b2b_done", cyc + 1, 1926);

        // 5: reset during bit 7
        send(11'h7FF, 1'b0, 16'hFFEE);
        repeat (8 * PER + 49) @(negedge clk);
        check("bit7_high", dshot_out, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_low", dshot_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", frame_done, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", tx_ready, 1);
        repeat (300) @(negedge clk);
        check("midrst_no_done", done_cnt, d0);
        send(11'h030, 1'b1, 16'h0617);
        wait_done(cyc);
        check("clean_after_rst", cyc + 1, 1926);
        send(11'h001, 1'b0, 16'h0022);
        wait_done(cyc);
`else
        // 6: streaming; one request yields repeated frames
        send(11'h7FF, 1'b0, 16'hFFEE);
        exp_q.push_back(16'hFFEE);
        exp_q.push_back(16'hFFEE);
        wait_done(cyc);
        check("rep_first_done", cyc + 1, 1926);
        wait_done(cyc);
        check("rep_period_2", cyc, 1926);
        wait_done(cyc);
        check("rep_period_3", cyc, 1926);
        check("rep_ready_last_gap", tx_ready, 1);
        check("rep_busy_last_gap", busy, 1);
        throttle  = 11'h6F5;
        telem_req = 1'b0;
        tx_valid  = 1'b1;
        exp_q.push_back(16'hDEA9);
        @(negedge clk);
        tx_valid = 1'b0;
        check("rep_switch_high", dshot_out, 1);
        check("rep_switch_word", tx_word, 16'hDEA9);
        check("rep_switch_ready", tx_ready, 0);
        wait_done(cyc);
        check("rep_switch_done", cyc + 1, 1926);
`endif
        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
